// File: rtl/mylab_ps2_rx.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 lines, deframes 11-bit frames,
// checks odd parity and stop bit, and decodes hex-digit make codes for a char display.
module mylab_ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kb_clock,
  input  logic       data,
  output logic [3:0] char,
  output logic       char_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic [1:0]    kb_sync, dat_sync;
  logic          kb_prev;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          break_pending;

  logic          fall, din, timeout, frame_done, frame_ok;
  logic [4:0]    key;

  // {mapped, hex value} for the make codes of 0-9 and A-F
  function automatic logic [4:0] key_map(input logic [7:0] code);
    case (code)
      8'h45: key_map = 5'h10;
      8'h16: key_map = 5'h11;
      8'h1E: key_map = 5'h12;
      8'h26: key_map = 5'h13;
      8'h25: key_map = 5'h14;
      8'h2E: key_map = 5'h15;
      8'h36: key_map = 5'h16;
      8'h3D: key_map = 5'h17;
      8'h3E: key_map = 5'h18;
      8'h46: key_map = 5'h19;
      8'h1C: key_map = 5'h1A;
      8'h32: key_map = 5'h1B;
      8'h21: key_map = 5'h1C;
      8'h23: key_map = 5'h1D;
      8'h24: key_map = 5'h1E;
      8'h2B: key_map = 5'h1F;
      default: key_map = 5'h00;
    endcase
  endfunction

  assign fall     = kb_prev & ~kb_sync[1];
  assign din      = dat_sync[1];
  // an edge in the same cycle as the limit keeps the frame alive
  assign timeout  = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES));
  assign frame_ok = (^{shreg, par_bit}) & din;
  assign key      = key_map(shreg);

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (fall && !din) state_nxt = DATA;
      DATA:   if (fall && bit_cnt == 3'd7) state_nxt = PARITY;
      PARITY: if (fall) state_nxt = STOP;
      STOP:   if (fall) begin
                state_nxt  = IDLE;
                frame_done = 1'b1;
              end
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kb_sync  <= 2'b11;
      dat_sync <= 2'b11;
      kb_prev  <= 1'b1;
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
    end else begin
      kb_sync  <= {kb_sync[0], kb_clock};
      dat_sync <= {dat_sync[0], data};
      kb_prev  <= kb_sync[1];
      state    <= state_nxt;
      if (state == IDLE) bit_cnt <= '0;
      else if (state == DATA && fall) bit_cnt <= bit_cnt + 3'd1;
      if (state == DATA && fall) shreg <= {din, shreg[7:1]};
      if (state == PARITY && fall) par_bit <= din;
      if (state == IDLE || fall || timeout) to_cnt <= '0;
      else to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char          <= '0;
      char_valid    <= 1'b0;
      scan_code     <= '0;
      frame_err     <= 1'b0;
      break_pending <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      frame_err  <= timeout;
      if (frame_done) begin
        if (frame_ok) begin
          scan_code <= shreg;
          if (shreg == 8'hF0) break_pending <= 1'b1;
          else if (shreg != 8'hE0) begin
            if (break_pending) break_pending <= 1'b0;
            else if (key[4]) begin
              char       <= key[3:0];
              char_valid <= 1'b1;
            end
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mylab_ps2_rx.sv
// Self-checking bench for mylab_ps2_rx: directed frames plus randomized traffic, checked
// every cycle against a bit-list frame model of the receiver.
module tb_mylab_ps2_rx;
  localparam int T = 100;

  logic       clk = 0, reset = 0, kb_clock = 1, data = 1;
  logic [3:0] char;
  logic       char_valid, frame_err;
  logic [7:0] scan_code;

  int compared = 0, mismatched = 0;
  int nvalid = 0, nerr = 0;

  mylab_ps2_rx #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .kb_clock(kb_clock), .data(data),
    .char(char), .char_valid(char_valid), .scan_code(scan_code), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // hex value v is produced by make code mcodes[v]
  logic [7:0] mcodes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  // model: raw line history, list of bits gathered since the start bit
  logic [2:0] hk = '1, hd = '1;
  bit         inframe = 0, m_brk = 0, fe, bv;
  bit         fb[$];
  int         cyc = 0, last_e = 0;
  logic [3:0] m_char = 0;
  logic       m_valid = 0, m_err = 0;
  logic [7:0] m_scan = 0;

  task automatic eval_frame();
    logic [7:0] b;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      b[i] = fb[i];
      ones += fb[i];
    end
    if (((ones + fb[8]) % 2 == 1) && fb[9]) begin
      m_scan = b;
      if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_brk = m_brk;
      else if (m_brk) m_brk = 0;
      else
        for (int v = 0; v < 16; v++)
          if (mcodes[v] == b) begin
            m_char  = 4'(v);
            m_valid = 1;
          end
    end else m_err = 1;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hk = '1; hd = '1; inframe = 0; fb.delete();
      m_char = 0; m_valid = 0; m_scan = 0; m_err = 0; m_brk = 0;
    end else begin
      cyc++;
      fe = hk[2] & ~hk[1];
      bv = hd[1];
      m_valid = 0;
      m_err   = 0;
      if (!inframe) begin
        if (fe && !bv) begin
          inframe = 1;
          fb.delete();
          last_e = cyc;
        end
      end else if (fe) begin
        fb.push_back(bv);
        last_e = cyc;
        if (fb.size() == 10) begin
          eval_frame();
          inframe = 0;
        end
      end else if (cyc - last_e == T + 1) begin
        inframe = 0;
        m_err   = 1;
      end
      hk = {hk[1:0], kb_clock};
      hd = {hd[1:0], data};
    end
  end

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("char", {4'h0, char}, {4'h0, m_char});
    chk("char_valid", {7'h0, char_valid}, {7'h0, m_valid});
    chk("scan_code", scan_code, m_scan);
    chk("frame_err", {7'h0, frame_err}, {7'h0, m_err});
    if (char_valid === 1'b1) nvalid++;
    if (frame_err === 1'b1) nerr++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // nb bits of the frame are sent; stretch != 0 uses fixed timing with bit 1 held high longer
  task automatic send(input logic [7:0] b, input bit badp = 0, input bit stop = 1,
                      input int nb = 11, input int stretch = 0);
    logic [10:0] f;
    f = {stop, (~^b) ^ badp, b, 1'b0};
    for (int i = 0; i < nb; i++) begin
      data = f[i];
      tick(stretch != 0 ? (i == 1 ? 4 + stretch : 4) : $urandom_range(3, 8));
      kb_clock = 0;
      tick(stretch != 0 ? 4 : $urandom_range(3, 8));
      kb_clock = 1;
    end
    tick(6);
  endtask

  task automatic clr();
    nvalid = 0;
    nerr   = 0;
  endtask

  initial begin
    logic [7:0] b;
    int r, nb;
    #1 reset = 1;
    tick(3);
    reset = 0;
    tick(3);
    chk("reset char", {4'h0, char}, 8'h00);
    chk("reset scan", scan_code, 8'h00);
    chk("reset valid", {7'h0, char_valid}, 8'h00);
    chk("reset err", {7'h0, frame_err}, 8'h00);

    clr(); send(8'h16);
    chk("s1 scan", scan_code, 8'h16);
    chk("s1 char", {4'h0, char}, 8'h01);
    chk("s1 pulses", 8'(nvalid), 8'd1);

    clr(); send(8'hF0); send(8'h16);
    chk("s2 scan", scan_code, 8'h16);
    chk("s2 pulses", 8'(nvalid), 8'd0);
    clr(); send(8'h16);
    chk("s2 repress pulses", 8'(nvalid), 8'd1);
    chk("s2 char", {4'h0, char}, 8'h01);

    clr(); send(8'h1C, 1);
    chk("s3 err pulses", 8'(nerr), 8'd1);
    chk("s3 char", {4'h0, char}, 8'h01);
    chk("s3 scan", scan_code, 8'h16);
    clr(); send(8'h29);
    chk("s3b scan", scan_code, 8'h29);
    chk("s3b pulses", 8'(nvalid + nerr), 8'd0);

    clr(); send(8'h5A, 0, 1, 5);
    tick(T + 10);
    chk("s4 timeout pulses", 8'(nerr), 8'd1);
    clr(); send(8'h23);
    chk("s4 char", {4'h0, char}, 8'h0D);
    chk("s4 pulses", 8'(nvalid), 8'd1);

    clr(); send(8'h1E, 0, 1, 6);
    reset = 1;
    tick(2);
    chk("s5 char", {4'h0, char}, 8'h00);
    chk("s5 scan", scan_code, 8'h00);
    reset = 0;
    tick(3);
    chk("s5 pulses", 8'(nvalid + nerr), 8'd0);
    send(8'h45);
    chk("s5 char 0", {4'h0, char}, 8'h00);
    chk("s5 scan 45", scan_code, 8'h45);
    chk("s5 valid", 8'(nvalid), 8'd1);

    // edge-to-edge spacing swept across the timeout limit
    for (int s = T - 10; s <= T - 4; s++) begin
      send(mcodes[$urandom_range(0, 15)], 0, 1, 11, s);
      tick(T + 20);
    end

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r < 5) b = mcodes[$urandom_range(0, 15)];
      else if (r == 5) b = 8'hF0;
      else if (r == 6) b = 8'hE0;
      else b = 8'($urandom_range(0, 255));
      nb = ($urandom_range(0, 14) == 0) ? $urandom_range(1, 10) : 11;
      send(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) != 0, nb);
      if (nb < 11) tick(T + 20);
      else tick($urandom_range(0, 20));
    end

    tick(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
